// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot, step, stall, redirect, trap.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen #(
  parameter int unsigned XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC =
    XLEN'(32'h0001_0000),
  parameter logic [XLEN-1:0] TRAP_VEC  =
    XLEN'(32'h0001_0100),
  parameter int unsigned STEP       = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_prev,
  output logic            pc_valid,
  output logic            redirected,
  output logic            pend_valid,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD_PEND = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_prev;
  logic            r_valid;
  logic            r_redirected;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_target;

  logic [XLEN-1:0] w_nxt_pc;
  logic            w_nxt_valid;
  logic            w_nxt_redirected;
  logic            w_nxt_pend_valid;
  logic [XLEN-1:0] w_nxt_pend_target;
  logic            w_apply;
  logic [XLEN-1:0] w_cand;
  logic            w_bad;
  logic [XLEN-1:0] w_cand_pc;
  logic [XLEN-1:0] w_step_pc;

  // The target that would be applied this edge: a fresh redirect
  // beats a queued one.
  assign w_cand = (r_state == HOLD_PEND && !redir_valid)
                ? r_pend_target : redir_target;

  assign w_step_pc = r_pc + XLEN'(STEP);

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] AMASK =
    XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  logic            r_misalign;
  logic [XLEN-1:0] r_bad_addr;

  assign w_bad = (w_cand & AMASK) != '0;

  // Record rejected targets at the moment they are applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_misalign <= w_apply & w_bad;
      if (w_apply && w_bad)
        r_bad_addr <= w_cand;
    end
  end

  assign misalign = r_misalign;
  assign bad_addr = r_bad_addr;
`else
  assign w_bad    = 1'b0;
  assign misalign = 1'b0;
  assign bad_addr = '0;
`endif

  assign w_cand_pc = w_bad ? TRAP_VEC : w_cand;

  // Next-state and next-PC selection by state and event priority.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_pc          = r_pc;
    w_nxt_valid       = r_valid;
    w_nxt_redirected  = 1'b0;
    w_nxt_pend_valid  = r_pend_valid;
    w_nxt_pend_target = r_pend_target;
    w_apply           = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_nxt_valid = 1'b1;
        w_nxt_state = RUN;
      end
      RUN: begin
        if (trap_req) begin
          w_nxt_pc         = TRAP_VEC;
          w_nxt_redirected = 1'b1;
        end else if (redir_valid && !stall) begin
          w_apply          = 1'b1;
          w_nxt_pc         = w_cand_pc;
          w_nxt_redirected = 1'b1;
        end else if (redir_valid) begin
          w_nxt_pend_target = redir_target;
          w_nxt_pend_valid  = 1'b1;
          w_nxt_state       = HOLD_PEND;
        end else if (!stall) begin
          w_nxt_pc = w_step_pc;
        end
      end
      HOLD_PEND: begin
        if (trap_req) begin
          w_nxt_pc         = TRAP_VEC;
          w_nxt_pend_valid = 1'b0;
          w_nxt_redirected = 1'b1;
          w_nxt_state      = RUN;
        end else if (stall) begin
          if (redir_valid)
            w_nxt_pend_target = redir_target;
        end else begin
          w_apply          = 1'b1;
          w_nxt_pc         = w_cand_pc;
          w_nxt_pend_valid = 1'b0;
          w_nxt_redirected = 1'b1;
          w_nxt_state      = RUN;
        end
      end
      default: begin
        w_nxt_state = BOOT;
      end
    endcase
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VEC;
      r_pc_prev     <= RESET_VEC;
      r_valid       <= 1'b0;
      r_redirected  <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_pc          <= w_nxt_pc;
      r_valid       <= w_nxt_valid;
      r_redirected  <= w_nxt_redirected;
      r_pend_valid  <= w_nxt_pend_valid;
      r_pend_target <= w_nxt_pend_target;
      if (w_nxt_pc != r_pc)
        r_pc_prev <= r_pc;
    end
  end

  assign pc         = r_pc;
  assign pc_prev    = r_pc_prev;
  assign pc_valid   = r_valid;
  assign redirected = r_redirected;
  assign pend_valid = r_pend_valid;

endmodule
